// File: rtl/z88_slotbus.sv
// Z88 slot bus controller: arbitrates blink chip-enables onto per-slot
// strobes, inserts per-slot wait states and returns slot read data to the CPU.
//
// state  | meaning
// IDLE   | no access in progress; strobes idle, cdi all-ones
// ACCESS | latched slot strobed; counting down its wait states
// HOLD   | access done; read data held until the CPU releases the request
module z88_slotbus #(
  parameter int NSLOTS = 5,
  parameter int AW     = 22,
  parameter int DW     = 8,
  parameter int WSW    = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [AW-1:0]         ma,
  input  logic [NSLOTS-1:0]     ce_n,
  input  logic                  roe_n,
  input  logic                  wrb_n,
  input  logic [DW-1:0]         wdata,
  input  logic [NSLOTS*DW-1:0]  slot_rdata,
  input  logic [NSLOTS*WSW-1:0] ws_cfg,
  input  logic [NSLOTS-1:0]     slot_present,
  output logic [AW-1:0]         slot_a,
  output logic [NSLOTS-1:0]     slot_ce_n,
  output logic [NSLOTS-1:0]     slot_oe_n,
  output logic [NSLOTS-1:0]     slot_we_n,
  output logic [DW-1:0]         slot_wd,
  output logic [DW-1:0]         cdi,
  output logic                  wait_n,
  output logic                  err
);

  localparam int IW = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;
  localparam int CW = $clog2(NSLOTS + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t         state;
  logic [IW-1:0]  slot_q;
  logic           rd_q;
  logic [WSW-1:0] cnt;
  logic           multi_q;

  logic           req;
  logic [CW-1:0]  n_sel;
  logic           one_sel;
  logic           multi_sel;
  logic [IW-1:0]  sel_idx;
  logic [WSW-1:0] sel_ws;
  logic           sel_present;
  logic [DW-1:0]  lat_rdata;
  logic           lat_ce_n;

  // Decode the incoming selects and look up the latched slot's data/enable.
  always_comb begin
    req         = (ce_n != '1) && (!roe_n || !wrb_n);
    n_sel       = '0;
    sel_idx     = '0;
    sel_ws      = '0;
    sel_present = 1'b0;
    lat_rdata   = '1;
    lat_ce_n    = 1'b1;
    for (int k = 0; k < NSLOTS; k++) begin
      if (!ce_n[k]) begin
        n_sel       = n_sel + CW'(1);
        sel_idx     = IW'(k);
        sel_ws      = ws_cfg[k*WSW +: WSW];
        sel_present = slot_present[k];
      end
      if (slot_q == IW'(k)) begin
        lat_rdata = slot_rdata[k*DW +: DW];
        lat_ce_n  = ce_n[k];
      end
    end
    one_sel   = (n_sel == CW'(1));
    multi_sel = (n_sel > CW'(1));
  end

  // Access sequencer with registered strobes, wait and error outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      slot_q    <= '0;
      rd_q      <= 1'b0;
      cnt       <= '0;
      multi_q   <= 1'b0;
      slot_a    <= '0;
      slot_wd   <= '0;
      slot_ce_n <= '1;
      slot_oe_n <= '1;
      slot_we_n <= '1;
      cdi       <= '1;
      wait_n    <= 1'b1;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          multi_q   <= req && multi_sel;
          slot_ce_n <= '1;
          slot_oe_n <= '1;
          slot_we_n <= '1;
          cdi       <= '1;
          wait_n    <= 1'b1;
          // Multi-select flags only its first cycle, not every cycle it persists.
          if (req && multi_sel && !multi_q) err <= 1'b1;
          if (req && one_sel && sel_present) begin
            state     <= ACCESS;
            slot_q    <= sel_idx;
            rd_q      <= !roe_n;
            slot_a    <= ma;
            slot_wd   <= wdata;
            cnt       <= sel_ws;
            slot_ce_n <= ce_n;
            slot_oe_n <= !roe_n ? ce_n : '1;
            slot_we_n <= !roe_n ? '1 : ce_n;
            wait_n    <= (sel_ws == '0);
            // Both strobes low resolves to a read but is still reported.
            err       <= !roe_n && !wrb_n;
          end
        end
        ACCESS: begin
          multi_q <= 1'b0;
          if (cnt == '0) begin
            state     <= HOLD;
            wait_n    <= 1'b1;
            slot_we_n <= '1;
            if (rd_q) cdi <= lat_rdata;
            else      slot_ce_n <= '1;
          end else begin
            cnt    <= cnt - WSW'(1);
            wait_n <= (cnt == WSW'(1));
          end
        end
        HOLD: begin
          if (lat_ce_n || (roe_n && wrb_n)) begin
            state     <= IDLE;
            slot_ce_n <= '1;
            slot_oe_n <= '1;
            slot_we_n <= '1;
            cdi       <= '1;
            wait_n    <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_z88_slotbus.sv
// Directed bench for z88_slotbus: ROM read, RAM write with wait states,
// absent card, multi-select, read/write collision and reset mid-access.
module tb_z88_slotbus;

  localparam int NSLOTS = 5;
  localparam int AW     = 22;
  localparam int DW     = 8;
  localparam int WSW    = 4;

  logic                  clk;
  logic                  reset_n;
  logic [AW-1:0]         ma;
  logic [NSLOTS-1:0]     ce_n;
  logic                  roe_n;
  logic                  wrb_n;
  logic [DW-1:0]         wdata;
  logic [NSLOTS*DW-1:0]  slot_rdata;
  logic [NSLOTS*WSW-1:0] ws_cfg;
  logic [NSLOTS-1:0]     slot_present;
  logic [AW-1:0]         slot_a;
  logic [NSLOTS-1:0]     slot_ce_n;
  logic [NSLOTS-1:0]     slot_oe_n;
  logic [NSLOTS-1:0]     slot_we_n;
  logic [DW-1:0]         slot_wd;
  logic [DW-1:0]         cdi;
  logic                  wait_n;
  logic                  err;

  int total;
  int passes;

  z88_slotbus #(.NSLOTS(NSLOTS), .AW(AW), .DW(DW), .WSW(WSW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ma           (ma),
    .ce_n         (ce_n),
    .roe_n        (roe_n),
    .wrb_n        (wrb_n),
    .wdata        (wdata),
    .slot_rdata   (slot_rdata),
    .ws_cfg       (ws_cfg),
    .slot_present (slot_present),
    .slot_a       (slot_a),
    .slot_ce_n    (slot_ce_n),
    .slot_oe_n    (slot_oe_n),
    .slot_we_n    (slot_we_n),
    .slot_wd      (slot_wd),
    .cdi          (cdi),
    .wait_n       (wait_n),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  initial begin
    total        = 0;
    passes       = 0;
    reset_n      = 1'b0;
    ma           = '0;
    ce_n         = '1;
    roe_n        = 1'b1;
    wrb_n        = 1'b1;
    wdata        = '0;
    slot_present = 5'b10111;
    ws_cfg       = {4'd2, 4'd0, 4'd7, 4'd3, 4'd0};
    slot_rdata   = {8'h44, 8'h33, 8'h5A, 8'h11, 8'hA5};

    // Reset state
    tick();
    tick();
    chk("rst_ce", 32'(slot_ce_n), 32'h1F);
    chk("rst_oe", 32'(slot_oe_n), 32'h1F);
    chk("rst_we", 32'(slot_we_n), 32'h1F);
    chk("rst_wait", 32'(wait_n), 32'h1);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_cdi", 32'(cdi), 32'hFF);
    chk("rst_a", 32'(slot_a), 32'h0);
    chk("rst_wd", 32'(slot_wd), 32'h0);
    reset_n = 1'b1;
    tick();

    // ROM read, zero wait states
    ma    = 22'h012345;
    ce_n  = 5'b11110;
    roe_n = 1'b0;
    tick();
    chk("rom_acc_ce", 32'(slot_ce_n), 32'h1E);
    chk("rom_acc_oe", 32'(slot_oe_n), 32'h1E);
    chk("rom_acc_we", 32'(slot_we_n), 32'h1F);
    chk("rom_acc_wait", 32'(wait_n), 32'h1);
    chk("rom_acc_a", 32'(slot_a), 32'h012345);
    chk("rom_acc_err", 32'(err), 32'h0);
    tick();
    chk("rom_hold_cdi", 32'(cdi), 32'hA5);
    chk("rom_hold_oe", 32'(slot_oe_n), 32'h1E);
    chk("rom_hold_wait", 32'(wait_n), 32'h1);
    tick();
    chk("rom_hold2_cdi", 32'(cdi), 32'hA5);
    ce_n = 5'b11111;
    tick();
    chk("rom_idle_ce", 32'(slot_ce_n), 32'h1F);
    chk("rom_idle_cdi", 32'(cdi), 32'hFF);
    roe_n = 1'b1;
    tick();

    // RAM write, three wait states; selects change mid-access
    ma    = 22'h3FFFFF;
    ce_n  = 5'b11101;
    wrb_n = 1'b0;
    wdata = 8'h3C;
    tick();
    chk("ram_wd", 32'(slot_wd), 32'h3C);
    chk("ram_a", 32'(slot_a), 32'h3FFFFF);
    chk("ram_ce", 32'(slot_ce_n), 32'h1D);
    chk("ram_oe", 32'(slot_oe_n), 32'h1F);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ram_we_%0d", i), 32'(slot_we_n), 32'h1D);
      chk($sformatf("ram_wait_%0d", i), 32'(wait_n), (i == 3) ? 32'h1 : 32'h0);
      if (i == 1) ce_n = 5'b11011;
      tick();
    end
    chk("ram_hold_we", 32'(slot_we_n), 32'h1F);
    chk("ram_hold_ce", 32'(slot_ce_n), 32'h1F);
    chk("ram_hold_wait", 32'(wait_n), 32'h1);
    tick();
    chk("gap_idle_ce", 32'(slot_ce_n), 32'h1F);
    chk("gap_idle_we", 32'(slot_we_n), 32'h1F);
    tick();
    chk("gap_next_we", 32'(slot_we_n), 32'h1B);
    chk("gap_next_wait", 32'(wait_n), 32'h0);
    ce_n  = 5'b11111;
    wrb_n = 1'b1;
    repeat (10) tick();
    chk("gap_done_we", 32'(slot_we_n), 32'h1F);

    // Absent card read
    ce_n  = 5'b10111;
    roe_n = 1'b0;
    tick();
    chk("abs_ce", 32'(slot_ce_n), 32'h1F);
    chk("abs_oe", 32'(slot_oe_n), 32'h1F);
    chk("abs_wait", 32'(wait_n), 32'h1);
    chk("abs_cdi", 32'(cdi), 32'hFF);
    tick();
    chk("abs_ce2", 32'(slot_ce_n), 32'h1F);
    ce_n  = 5'b11111;
    roe_n = 1'b1;
    tick();

    // Multi-select
    ce_n  = 5'b11100;
    roe_n = 1'b0;
    tick();
    chk("multi_err", 32'(err), 32'h1);
    chk("multi_ce", 32'(slot_ce_n), 32'h1F);
    chk("multi_oe", 32'(slot_oe_n), 32'h1F);
    chk("multi_cdi", 32'(cdi), 32'hFF);
    tick();
    chk("multi_err2", 32'(err), 32'h0);
    tick();
    chk("multi_err3", 32'(err), 32'h0);
    ce_n  = 5'b11111;
    roe_n = 1'b1;
    tick();

    // Read and write strobes together on slot 4 (two wait states)
    ce_n  = 5'b01111;
    roe_n = 1'b0;
    wrb_n = 1'b0;
    tick();
    chk("both_err", 32'(err), 32'h1);
    chk("both_oe", 32'(slot_oe_n), 32'h0F);
    chk("both_we", 32'(slot_we_n), 32'h1F);
    chk("both_wait", 32'(wait_n), 32'h0);
    tick();
    chk("both_err2", 32'(err), 32'h0);
    tick();
    chk("both_last_wait", 32'(wait_n), 32'h1);
    tick();
    chk("both_cdi", 32'(cdi), 32'h44);
    chk("both_hold_oe", 32'(slot_oe_n), 32'h0F);
    ce_n  = 5'b11111;
    roe_n = 1'b1;
    wrb_n = 1'b1;
    tick();
    chk("both_idle_cdi", 32'(cdi), 32'hFF);

    // Reset mid-access on slot 2 (seven wait states)
    ma    = 22'h0000AA;
    ce_n  = 5'b11011;
    roe_n = 1'b0;
    tick();
    tick();
    tick();
    chk("mid_ce", 32'(slot_ce_n), 32'h1B);
    reset_n = 1'b0;
    tick();
    chk("mid_rst_ce", 32'(slot_ce_n), 32'h1F);
    chk("mid_rst_oe", 32'(slot_oe_n), 32'h1F);
    chk("mid_rst_wait", 32'(wait_n), 32'h1);
    chk("mid_rst_a", 32'(slot_a), 32'h0);
    chk("mid_rst_wd", 32'(slot_wd), 32'h0);
    tick();
    chk("mid_rst_hold_ce", 32'(slot_ce_n), 32'h1F);
    reset_n = 1'b1;
    tick();
    chk("post_ce", 32'(slot_ce_n), 32'h1B);
    chk("post_oe", 32'(slot_oe_n), 32'h1B);
    chk("post_wait", 32'(wait_n), 32'h0);
    chk("post_a", 32'(slot_a), 32'h0000AA);
    repeat (7) tick();
    chk("post_last_wait", 32'(wait_n), 32'h1);
    tick();
    chk("post_cdi", 32'(cdi), 32'h5A);
    ce_n  = 5'b11111;
    roe_n = 1'b1;
    tick();
    chk("post_idle_ce", 32'(slot_ce_n), 32'h1F);
    chk("post_idle_cdi", 32'(cdi), 32'hFF);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/z88_slotbus.md
Z88_SLOTBUS -- requirements
Module: z88_slotbus

Interface
- REQ-001: Parameter NSLOTS, 5, number of memory slots; slot 0 is internal ROM, slot 1 is internal RAM, slots 2..NSLOTS-1 are cards SE1..SE3.
- REQ-002: Parameter AW, 22, width of the memory address bus.
- REQ-003: Parameter DW, 8, width of the data bus.
- REQ-004: Parameter WSW, 4, width of each slot's wait-state count field.
- REQ-005: clk  in  1  single clock; all logic is synchronous to its rising edge.
- REQ-006: reset_n  in  1  reset, synchronous and active-low.
- REQ-007: ma  in  AW  memory address from the blink.
- REQ-008: ce_n  in  NSLOTS  per-slot chip enables from the blink, active low.
- REQ-009: roe_n  in  1  read strobe, active low.
- REQ-010: wrb_n  in  1  write strobe, active low.
- REQ-011: wdata  in  DW  CPU write data.
- REQ-012: slot_rdata  in  NSLOTS*DW  read data from each slot; slot k occupies bits [k*DW +: DW].
- REQ-013: ws_cfg  in  NSLOTS*WSW  wait states per slot; slot k occupies bits [k*WSW +: WSW].
- REQ-014: slot_present  in  NSLOTS  slot populated flag, one bit per slot.
- REQ-015: slot_a  out  AW  registered address to the slots.
- REQ-016: slot_ce_n, slot_oe_n, slot_we_n  out  NSLOTS each  registered per-slot strobes, active low.
- REQ-017: slot_wd  out  DW  registered write data.
- REQ-018: cdi  out  DW  read data to the CPU.
- REQ-019: wait_n  out  1  CPU wait request, active low.
- REQ-020: err  out  1  one-cycle pulse on an illegal request.

Function
- REQ-021: The FSM SHALL have three states, IDLE, ACCESS and HOLD, encoded in 2 bits.
- REQ-022: A request is when one or more ce_n bits are low AND (roe_n=0 OR wrb_n=0).
- REQ-023: IDLE SHALL transition to ACCESS when a request is present, exactly one ce_n bit is low, and that slot's slot_present bit is 1.
  - On that edge the block latches the slot index, ma, wdata and the operation; the operation is read if roe_n=0, otherwise write.
  - It loads cnt with that slot's ws_cfg value.
- REQ-024: In ACCESS, the latched slot's slot_ce_n SHALL be 0.
  - slot_oe_n SHALL be 0 for a read; slot_we_n SHALL be 0 for a write.
  - All other slots' strobes SHALL be 1.
- REQ-025: In ACCESS, cnt SHALL decrement each cycle; when cnt=0 the FSM SHALL move to HOLD.
  - ACCESS therefore lasts ws_cfg+1 cycles; a count of 0 gives one cycle.
- REQ-026: For a read, the transition out of ACCESS SHALL capture the latched slot's slot_rdata into the cdi register.
- REQ-027: wait_n SHALL be 0 in every ACCESS cycle except the last one (cnt=0); it SHALL be 1 in all other states.
- REQ-028: In HOLD, slot_we_n SHALL be 1 and slot_oe_n and slot_ce_n SHALL stay asserted for a read.
  - cdi SHALL keep its captured value.
  - HOLD SHALL return to IDLE when the latched ce_n bit is 1 OR both roe_n and wrb_n are 1.
- REQ-029: In IDLE, all slot strobes SHALL be 1 and cdi SHALL be all-ones, except as stated in REQ-030.
- REQ-030: A request to an absent slot (slot_present=0) SHALL not leave IDLE and SHALL not assert wait_n or any strobe.
  - A read returns cdi = all-ones; a write is dropped.
- REQ-031: A request with more than one ce_n bit low SHALL not start an access.
  - It SHALL pulse err for one cycle on the first cycle it is seen; cdi SHALL be all-ones.
- REQ-032: roe_n=0 and wrb_n=0 together SHALL be treated as a read and SHALL pulse err for one cycle on the ACCESS entry edge.
- REQ-033: ce_n or the strobes changing during ACCESS SHALL be ignored; the latched values rule until HOLD.
- REQ-034: No new access SHALL start in the same cycle the FSM returns to IDLE; there is at least one IDLE cycle between accesses.
- REQ-035: cnt SHALL be WSW bits wide and SHALL never wrap; it is loaded only on ACCESS entry.

Reset
- REQ-036: When reset_n=0 at a rising edge, the block SHALL enter IDLE on that edge, including mid-ACCESS or mid-HOLD.
  - Outputs after that edge: slot_ce_n, slot_oe_n, slot_we_n all ones; wait_n=1; err=0; cdi all-ones; slot_a=0; slot_wd=0; cnt=0.
- REQ-037: Requests present while reset_n=0 SHALL be ignored.
  - Arbitration SHALL resume on the first edge with reset_n=1.

Verification
- REQ-038: ROM read.
  - Stimulus: ws_cfg[0]=0, ce_n=5'b11110, roe_n=0, slot_rdata slot0=8'hA5.
  - Response: one ACCESS cycle, wait_n stays 1, cdi=8'hA5 in HOLD, IDLE after ce_n rises.
- REQ-039: RAM write with wait states.
  - Stimulus: ws_cfg[1]=3, ce_n[1]=0, wrb_n=0, wdata=8'h3C.
  - Response: slot_we_n[1]=0 for 4 cycles, wait_n=0 for 3 cycles, slot_wd=8'h3C, then slot_we_n[1]=1 in HOLD.
- REQ-040: Absent card read.
  - Stimulus: slot_present[3]=0, ce_n[3]=0, roe_n=0.
  - Response: cdi=8'hFF, no strobe asserted, wait_n=1, state stays IDLE.
- REQ-041: Multi-select.
  - Stimulus: ce_n=5'b11100 with roe_n=0.
  - Response: err pulses exactly 1 cycle, no strobe asserted, cdi=8'hFF.
- REQ-042: Reset mid-access.
  - Stimulus: ws_cfg[2]=7, reset_n driven low on the 3rd ACCESS cycle.
  - Response: next edge gives all strobes 1, wait_n=1, IDLE; a new request after reset_n=1 completes normally.
